// File: rtl/counter_step_arbiter.sv
// Round-robin arbiter that shares one up/down counter between two burst requesters.
// Drives the counter's enable, direction and clear, and keeps a shadow copy of its value.
module counter_step_arbiter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic             dir0_i,
  input  logic [LEN_W-1:0] len0_i,
  output logic             ack0_o,
  output logic             done0_o,
  input  logic             req1_i,
  input  logic             dir1_i,
  input  logic [LEN_W-1:0] len1_i,
  output logic             ack1_o,
  output logic             done1_o,
  input  logic             hold_i,
  input  logic             clr_i,
  output logic             ce_o,
  output logic             ctr_o,
  output logic             cnt_rst_o,
  output logic             busy_o,
  output logic             owner_o,
  output logic [CNT_W-1:0] shadow_o
);

  typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   shadow_q, shadow_d;

  logic               gnt_any;
  logic               gnt_sel;
  logic               idle_grant;
  logic               step;
  logic [LEN_W-1:0]   sel_len;

  // Grant selection: a lone request wins, a tie goes to the requester not served last.
  always_comb begin
    gnt_any    = req0_i | req1_i;
    gnt_sel    = (req0_i & req1_i) ? ~last_q : req1_i;
    idle_grant = (state_q == StIdle) & ~clr_i & gnt_any;
    sel_len    = gnt_sel ? len1_i : len0_i;
    step       = (state_q == StRun) & ~hold_i;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    owner_d  = owner_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          state_d = StClr;
        end else if (gnt_any) begin
          dir_d   = gnt_sel ? dir1_i : dir0_i;
          rem_d   = sel_len;
          owner_d = gnt_sel;
          last_d  = gnt_sel;
          state_d = (sel_len == '0) ? StDone : StRun;
        end
      end
      StClr: begin
        shadow_d = '0;
        state_d  = StIdle;
      end
      StRun: begin
        if (step) begin
          rem_d    = rem_q - LEN_W'(1);
          shadow_d = dir_q ? shadow_q + CNT_W'(1) : shadow_q - CNT_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; last grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      rem_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
    end
  end

  // Output decode from state, plus the combinational ack/enable paths.
  always_comb begin
    ack0_o    = idle_grant & ~gnt_sel;
    ack1_o    = idle_grant & gnt_sel;
    done0_o   = (state_q == StDone) & ~owner_q;
    done1_o   = (state_q == StDone) & owner_q;
    ce_o      = step;
    ctr_o     = dir_q;
    cnt_rst_o = (state_q == StClr);
    busy_o    = (state_q != StIdle);
    owner_o   = owner_q;
    shadow_o  = shadow_q;
  end

endmodule

// File: tb/tb_counter_step_arbiter.sv
// Bench for counter_step_arbiter: directed scenarios followed by random traffic, checked by a
// scoreboard of captured requests and a burst-level reference model.
module tb_counter_step_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req0_i, dir0_i, req1_i, dir1_i, hold_i, clr_i;
  logic [3:0] len0_i, len1_i;
  logic       ack0_o, done0_o, ack1_o, done1_o;
  logic       ce_o, ctr_o, cnt_rst_o, busy_o, owner_o;
  logic [3:0] shadow_o;

  typedef struct {bit dir; int len;} req_t;
  req_t q0[$];
  req_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  counter_step_arbiter #(.CNT_W(4), .LEN_W(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req0_i    (req0_i),
    .dir0_i    (dir0_i),
    .len0_i    (len0_i),
    .ack0_o    (ack0_o),
    .done0_o   (done0_o),
    .req1_i    (req1_i),
    .dir1_i    (dir1_i),
    .len1_i    (len1_i),
    .ack1_o    (ack1_o),
    .done1_o   (done1_o),
    .hold_i    (hold_i),
    .clr_i     (clr_i),
    .ce_o      (ce_o),
    .ctr_o     (ctr_o),
    .cnt_rst_o (cnt_rst_o),
    .busy_o    (busy_o),
    .owner_o   (owner_o),
    .shadow_o  (shadow_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (burst level) ----------------
  bit m_valid = 0;
  bit m_clr, m_done, m_run, m_owner, m_last, m_dir;
  int m_rem, m_len, m_shadow, m_dut_ce;

  always @(negedge clk_i) begin
    bit idle, grant, w;
    req_t r;
    idle  = !m_run && !m_done && !m_clr;
    grant = idle && !clr_i && (req0_i || req1_i);
    w     = (req0_i && req1_i) ? !m_last : req1_i;
    if (m_valid) begin
      chk("ack0", ack0_o, grant && !w);
      chk("ack1", ack1_o, grant && w);
      chk("ce", ce_o, m_run && !hold_i);
      chk("cnt_rst", cnt_rst_o, m_clr);
      chk("done0", done0_o, m_done && !m_owner);
      chk("done1", done1_o, m_done && m_owner);
      chk("busy", busy_o, !idle);
      chk("owner", owner_o, m_owner);
      chk("ctr", ctr_o, m_dir);
      chk("shadow", shadow_o, m_shadow);
      if (m_run && ce_o === 1'b1) m_dut_ce++;
      if (m_done) chk("burst_steps", m_dut_ce, m_len);
    end
    if (rst_i) begin
      m_valid = 1; m_clr = 0; m_done = 0; m_run = 0; m_owner = 0; m_last = 1; m_dir = 0;
      m_rem = 0; m_len = 0; m_shadow = 0; m_dut_ce = 0;
    end else if (m_valid) begin
      if (m_clr) begin
        m_clr = 0; m_shadow = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (!hold_i) begin
          m_shadow = (m_shadow + (m_dir ? 1 : 15)) % 16;
          m_rem--;
          if (m_rem == 0) begin m_run = 0; m_done = 1; end
        end
      end else if (clr_i) begin
        m_clr = 1;
      end else if (grant) begin
        if ((w ? q1.size() : q0.size()) == 0) begin
          chk("scoreboard_empty", 1, 0);
          r.dir = 0; r.len = 0;
        end else begin
          r = w ? q1.pop_front() : q0.pop_front();
        end
        m_owner = w; m_last = w; m_dir = r.dir; m_len = r.len; m_rem = r.len; m_dut_ce = 0;
        if (r.len == 0) m_done = 1; else m_run = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    logic a0, a1;
    @(negedge clk_i);
    a0 = ack0_o; a1 = ack1_o;
    @(posedge clk_i);
    #1;
    if (a0 === 1'b1 && !rst_i) req0_i = 0;
    if (a1 === 1'b1 && !rst_i) req1_i = 0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise a request unless that requester already has one pending.
  task automatic issue(int n, bit d, int l);
    req_t r;
    r.dir = d; r.len = l;
    if (n == 0 && !req0_i) begin
      req0_i = 1; dir0_i = d; len0_i = 4'(l); q0.push_back(r);
    end else if (n == 1 && !req1_i) begin
      req1_i = 1; dir1_i = d; len1_i = 4'(l); q1.push_back(r);
    end
  endtask

  initial begin
    rst_i = 1; req0_i = 0; req1_i = 0; dir0_i = 0; dir1_i = 0;
    len0_i = 0; len1_i = 0; hold_i = 0; clr_i = 0;
    ticks(2);
    rst_i = 0;
    ticks(2);
    // Up burst of 5, then down burst of 7 that wraps through zero.
    issue(0, 1, 5); ticks(10);
    issue(1, 0, 7); ticks(12);
    // Both requesters always pending: grants must alternate.
    for (int i = 0; i < 40; i++) begin
      issue(0, $urandom_range(0, 1), $urandom_range(0, 3));
      issue(1, $urandom_range(0, 1), $urandom_range(0, 3));
      tick();
    end
    ticks(12);
    // Hold mid-burst.
    issue(0, 1, 4); ticks(2);
    hold_i = 1; ticks(3); hold_i = 0; ticks(8);
    // Clear together with a request, then clear during a burst.
    clr_i = 1; issue(0, 1, 2); tick(); clr_i = 0; ticks(6);
    issue(1, 1, 6); ticks(2); clr_i = 1; tick(); clr_i = 0; ticks(8);
    // Zero-length burst.
    issue(0, 0, 0); ticks(4);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      hold_i = ($urandom_range(0, 3) == 0);
      clr_i  = ($urandom_range(0, 15) == 0);
      rst_i  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0)
        issue(0, $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0)
        issue(1, $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 5));
      tick();
    end
    hold_i = 0; clr_i = 0; rst_i = 0;
    ticks(40);
    // Reset in the middle of a burst: no done, outputs back to zero.
    issue(1, 1, 9); ticks(3);
    rst_i = 1; tick(); rst_i = 0; ticks(4);
    // Everything issued must have been granted.
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
